// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC sequencer and prefetch FIFO between core redirect logic and instruction memory.
// Define IMEM_FETCH_BOUND_CHECK_EN to add the out-of-range FAULT state and sticky fault_o.
module imem_fetch_ctrl #(
   parameter int          MEM_SIZE   = 1024,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [15:0] RESET_PC   = 16'h0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        redirect_i,
   input  logic [15:0] redirect_pc_i,
   output logic [15:0] imem_addr_o,
   input  logic [15:0] imem_instr_i,
   output logic [15:0] instr_o,
   output logic [15:0] pc_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        busy_o,
   output logic        fault_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [16:0] LIMIT = 17'(MEM_SIZE * 4);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   logic [1:0]    state, state_n;
   logic [15:0]   pc;
   logic [CW-1:0] count;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0]   fifo_instr [FIFO_DEPTH];
   logic [15:0]   fifo_pc    [FIFO_DEPTH];
   logic          pop, room, push, go;
   logic          unused_bits;
   assign unused_bits = ^{redirect_pc_i[1:0], LIMIT};
   assign pop  = valid_o && ready_i;
   assign room = count < CW'(FIFO_DEPTH) || pop;
   // a redirect outside FETCH always lands in IDLE, even with en_i high
   assign go   = en_i && !(redirect_i && state != FETCH);
`ifdef IMEM_FETCH_BOUND_CHECK_EN
   localparam logic [1:0] FAULT = 2'd2;
   logic oob;
   assign oob     = {1'b0, pc} >= LIMIT;
   assign push    = state == FETCH && !redirect_i && room && !oob;
   assign state_n = (state == FETCH && !redirect_i && room && oob) ? FAULT :
                    (state == FAULT && !redirect_i) ? FAULT : go ? FETCH : IDLE;
   assign fault_o = state == FAULT;
`else
   assign push    = state == FETCH && !redirect_i && room;
   assign state_n = go ? FETCH : IDLE;
   assign fault_o = 1'b0;
`endif
   assign imem_addr_o = pc;
   assign valid_o     = count != '0;
   assign instr_o     = valid_o ? fifo_instr[rd_ptr] : '0;
   assign pc_o        = valid_o ? fifo_pc[rd_ptr] : '0;
   assign busy_o      = state == FETCH || valid_o;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_n;
         if (redirect_i) begin
            pc     <= {redirect_pc_i[15:2], 2'b00};
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            pc     <= push ? pc + 16'd4 : pc;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_instr_i;
         fifo_pc[wr_ptr]    <= pc;
      end
   end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed plan checks plus randomized run against a queue-based fetch model.
// Build with IMEM_FETCH_BOUND_CHECK_EN to exercise the FAULT path with MEM_SIZE=4.
module tb_imem_fetch_ctrl;
`ifdef IMEM_FETCH_BOUND_CHECK_EN
   localparam int MS = 4;
   localparam bit BOUND = 1'b1;
`else
   localparam int MS = 1024;
   localparam bit BOUND = 1'b0;
`endif
   localparam int DEPTH = 2;
   logic        clk = 1'b0, rst, en, redirect, ready;
   logic [15:0] rpc, imem_addr, imem_instr, instr, pc_o;
   logic        valid, busy, fault;
   logic [15:0] mem [1024];
   int          errors = 0, checks = 0;
   logic [31:0] m_q [$];
   logic [15:0] m_pc;
   bit          m_run, m_fault;

   always #5 clk = ~clk;
   assign imem_instr = mem[imem_addr[11:2]];

   imem_fetch_ctrl #(.MEM_SIZE(MS), .FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .redirect_i(redirect), .redirect_pc_i(rpc),
      .imem_addr_o(imem_addr), .imem_instr_i(imem_instr), .instr_o(instr), .pc_o(pc_o),
      .valid_o(valid), .ready_i(ready), .busy_o(busy), .fault_o(fault));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: a queue of {instr, pc}, a running flag and a fault flag
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_q.delete();
         m_pc = 16'h0000;
         m_run = 1'b0;
         m_fault = 1'b0;
      end else begin
         bit pop, room;
         pop  = m_q.size() != 0 && ready;
         room = m_q.size() < DEPTH || pop;
         if (redirect) begin
            m_q.delete();
            m_pc = {rpc[15:2], 2'b00};
            m_run = m_run && en;
            m_fault = 1'b0;
         end else begin
            if (pop) void'(m_q.pop_front());
            if (m_run && room) begin
               if (BOUND && int'(m_pc) >= MS * 4) m_fault = 1'b1;
               else begin
                  m_q.push_back({mem[m_pc[11:2]], m_pc});
                  m_pc = m_pc + 16'd4;
               end
            end
            m_run = !m_fault && en;
         end
      end
   end

   initial forever begin
      logic [31:0] head;
      @(negedge clk);
      head = m_q.size() != 0 ? m_q[0] : 32'h0;
      chk("valid", 32'(valid), 32'(m_q.size() != 0));
      chk("instr", 32'(instr), 32'(head[31:16]));
      chk("pc",    32'(pc_o),  32'(head[15:0]));
      chk("addr",  32'(imem_addr), 32'(m_pc));
      chk("busy",  32'(busy),  32'(m_run || m_q.size() != 0));
      chk("fault", 32'(fault), 32'(m_fault));
   end

   initial begin
      rst = 1'b1; en = 1'b0; redirect = 1'b0; ready = 1'b0; rpc = 16'h0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
      mem[4] = 16'h5555; mem[5] = 16'h6666; mem[6] = 16'h7777;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_instr", 32'(instr), 32'h0);
      rst = 1'b0; en = 1'b1; ready = 1'b1;
      @(negedge clk);
      chk("lat_valid0", 32'(valid), 32'd0);
      @(negedge clk);
      chk("lat_valid1", 32'(valid), 32'd1);
      chk("s_i0", 32'(instr), 32'h1111); chk("s_p0", 32'(pc_o), 32'h0);
      @(negedge clk);
      chk("s_i1", 32'(instr), 32'h2222); chk("s_p1", 32'(pc_o), 32'h4);
      @(negedge clk);
      chk("s_i2", 32'(instr), 32'h3333); chk("s_p2", 32'(pc_o), 32'h8);
      @(negedge clk);
      chk("s_i3", 32'(instr), 32'h4444); chk("s_p3", 32'(pc_o), 32'hC);
`ifdef IMEM_FETCH_BOUND_CHECK_EN
      @(negedge clk);
      chk("bnd_fault", 32'(fault), 32'd1);
      chk("bnd_addr", 32'(imem_addr), 32'h10);
      chk("bnd_valid", 32'(valid), 32'd0);
      redirect = 1'b1; rpc = 16'h0;
      @(negedge clk);
      chk("bnd_clear", 32'(fault), 32'd0);
      redirect = 1'b0;
      repeat (2) @(negedge clk);
      chk("bnd_restart", 32'(instr), 32'h1111);
`else
      redirect = 1'b1; rpc = 16'h0; ready = 1'b0;
      @(negedge clk);
      redirect = 1'b0;
      repeat (4) @(negedge clk);
      chk("bp_addr", 32'(imem_addr), 32'h8);
      chk("bp_instr", 32'(instr), 32'h1111);
      ready = 1'b1;
      @(negedge clk);
      chk("bp_rel1", 32'(instr), 32'h2222); chk("bp_relp1", 32'(pc_o), 32'h4);
      @(negedge clk);
      chk("bp_rel2", 32'(instr), 32'h3333);
      ready = 1'b0; redirect = 1'b1; rpc = 16'h0013;
      @(negedge clk);
      chk("rd_valid", 32'(valid), 32'd0);
      chk("rd_addr", 32'(imem_addr), 32'h10);
      redirect = 1'b0; ready = 1'b1;
      @(negedge clk);
      chk("rd_instr", 32'(instr), 32'h5555); chk("rd_pc", 32'(pc_o), 32'h10);
      en = 1'b0;
      @(negedge clk);
      chk("en_last", 32'(instr), 32'h6666);
      @(negedge clk);
      chk("en_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("en_frozen", 32'(imem_addr), 32'h18);
      en = 1'b1;
      repeat (2) @(negedge clk);
      chk("en_resume", 32'(pc_o), 32'h18);
      chk("en_resume_i", 32'(instr), 32'h7777);
      #3 rst = 1'b1;
      #1 chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_addr", 32'(imem_addr), 32'h0);
      @(negedge clk);
      rst = 1'b0;
`endif
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         en = $urandom_range(0, 9) != 0;
         ready = $urandom_range(0, 3) != 0;
         redirect = $urandom_range(0, 15) == 0;
         if (BOUND) rpc = 16'($urandom_range(0, 5) << 2) | 16'($urandom_range(0, 3));
         else rpc = $urandom_range(0, 3) == 0 ? 16'hFFF4 : 16'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end
      @(negedge clk);
      #1 $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer sitting between the core's PC/redirect logic and the 16-bit instruction memory.
- Drives the memory byte address with a 4-byte PC stride, because the memory indexes words by addr[ADDR_WIDTH+1:2].
- Captures the combinational read data into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake, with flush on branch/jump redirect and start/stop control.

Parameters:
- MEM_SIZE, 1024, instruction memory depth in 16-bit words.
- FIFO_DEPTH, 2, prefetch entries; power of two, >= 2.
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk_i  input  1  clock; all state on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- en_i  input  1  fetch enable: start/continue fetching.
- redirect_i  input  1  one-cycle redirect strobe (taken branch/jump).
- redirect_pc_i  input  16  redirect target byte address.
- imem_addr_o  output  16  byte address to instruction memory.
- imem_instr_i  input  16  combinational read data for imem_addr_o.
- instr_o  output  16  head-of-FIFO instruction.
- pc_o  output  16  byte address of instr_o.
- valid_o  output  1  instr_o/pc_o are valid.
- ready_i  input  1  decode accepts; pop when valid_o && ready_i.
- busy_o  output  1  state is FETCH or FIFO is non-empty.
- fault_o  output  1  sticky fetch fault (optional feature only; otherwise tied 0).

Behaviour:
- Reset values (asynchronous): pc = RESET_PC; FIFO empty; state = IDLE; imem_addr_o = RESET_PC; valid_o = 0; instr_o = 0; pc_o = 0; busy_o = 0; fault_o = 0.
- imem_addr_o = pc register, driven with no combinational path from inputs.
- States:
  - IDLE: no fetch. en_i=1 -> FETCH.
  - FETCH: fetch when allowed. en_i=0 -> IDLE; fetch from this cycle is still pushed if allowed.
  - FAULT: optional feature only.
- Push condition: state==FETCH && !redirect_i && (count<FIFO_DEPTH || pop).
  - On push: entry {imem_instr_i, pc} is written and pc <= pc+4.
  - Simultaneous push and pop when full is legal; count stays FIFO_DEPTH.
- Pop: valid_o && ready_i removes the head.
  - valid_o = (count != 0).
  - instr_o/pc_o hold stable while valid_o && !ready_i.
  - instr_o/pc_o are 0 when the FIFO is empty.
- Latency: an address presented in cycle N is captured at the end of N; valid_o is high in N+1.
- Redirect (any state, highest priority):
  - FIFO cleared, pc <= redirect_pc_i, no push that cycle.
  - A pop in the same cycle is still the consumer's accept, but the head is discarded anyway.
  - valid_o=0 the next cycle; the first target instruction is valid 2 cycles after the redirect.
  - redirect_i in IDLE loads pc and stays in IDLE.
- redirect_pc_i[1:0] is ignored (forced to 0).
- pc arithmetic is 16-bit and wraps 16'hFFFC -> 16'h0000 (without the optional feature).
- Reset mid-operation: immediate return to reset values; the in-flight fetch is lost.
- Full FIFO with ready_i=0: pc and imem_addr_o hold; no push.

Optional Feature:
- Macro: IMEM_FETCH_BOUND_CHECK_EN.
- Defined:
  - Transition FETCH -> FAULT happens when pc >= MEM_SIZE*4 at a would-be push.
  - No push in that cycle; fault_o=1 (sticky).
  - FAULT performs no fetch; the FIFO still drains.
  - Only redirect_i (-> IDLE with new pc, fault_o=0) or reset leaves FAULT.
- Not defined: no FAULT state, fault_o tied 0, pc wraps freely, and out-of-range reads return whatever the memory supplies.

Test Plan:
- Reset, en_i=1, ready_i=1, mem[0..3] = 16'h1111, 2222, 3333, 4444:
  - Required: valid_o rises in cycle 2 after en_i.
  - Required: back-to-back instr_o = 1111, 2222, 3333, 4444 with pc_o = 0, 4, 8, C.
- Backpressure, ready_i=0 for 5 cycles:
  - Required: FIFO fills with 2 entries, imem_addr_o holds 16'h0008, instr_o stays 1111.
  - Required: after release, stream continues without loss or duplication.
- Redirect to 16'h0010 while the FIFO is full:
  - Required: next cycle valid_o=0, imem_addr_o=16'h0010.
  - Required: 2 cycles after the redirect, instr_o=mem[4], pc_o=16'h0010.
- en_i drops mid-stream:
  - Required: no further pushes and pc frozen.
  - Required: the FIFO drains, then busy_o=0.
  - Required: re-enable resumes at the frozen pc.
- Reset asserted asynchronously mid-fetch with 1 entry queued:
  - Required: valid_o=0 and imem_addr_o=RESET_PC immediately, without waiting for a clock.
- With IMEM_FETCH_BOUND_CHECK_EN, MEM_SIZE=4, start at pc 0:
  - Required: 4 instructions delivered, then fault_o=1 at pc=16'h0010.
  - Required: redirect to 0 clears fault_o and fetch restarts.
